// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: first-word-fall-through byte FIFO feeding a back-to-back 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1 framing).
module uart_tx_buffered #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset_n,
  input  logic                        i_Write,
  input  logic [7:0]                  i_Data,
  output logic                        o_Full,
  output logic                        o_Empty,
  output logic [$clog2(FIFO_DEPTH):0] o_Count,
  output logic                        o_Overflow,
  input  logic                        i_Clear_Overflow,
  output logic                        o_TX,
  output logic                        o_Busy_TX
);

  localparam int DIVIDER = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int BW      = $clog2(DIVIDER);

  localparam logic [BW-1:0] BAUD_RELOAD = BW'(DIVIDER - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // Acceptance looks only at the registered full flag, so a pop in the same
  // cycle never rescues a write aimed at a full FIFO.
  assign push = i_Write & ~full_q & i_Reset_n;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    ovf_d   = ovf_q;
    if (i_Write && full_q) begin
      ovf_d = 1'b1;
    end else if (i_Clear_Overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_Data;
    end
  end

  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;

  // ---------------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          baud_zero;

  assign baud_zero = (baud_q == '0);

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty_q) state_d = S_START;
      S_START: if (baud_zero) state_d = S_DATA;
      S_DATA: begin
        if (baud_zero && bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (baud_zero) state_d = S_STOP;
`endif
      S_STOP:  if (baud_zero) state_d = empty_q ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // Line level, pop strobe and counters; the stop bit chains straight into
  // the next start bit when another byte is already queued.
  always_comb begin
    tx_d    = tx_q;
    busy_d  = busy_q;
    baud_d  = baud_zero ? baud_q : baud_q - BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = BAUD_RELOAD;
        end
      end
      S_START: begin
        if (baud_zero) begin
          tx_d   = shift_q[0];
          bit_d  = '0;
          baud_d = BAUD_RELOAD;
        end
      end
      S_DATA: begin
        if (baud_zero) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d = ^shift_q;
`else
            tx_d = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_d];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_zero) begin
          tx_d   = 1'b1;
          baud_d = BAUD_RELOAD;
        end
      end
`endif
      S_STOP: begin
        if (baud_zero) begin
          baud_d = BAUD_RELOAD;
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
          end else begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign o_TX      = tx_q;
  assign o_Busy_TX = busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-timeline reference model checked every cycle,
// plus directed scenarios with hand-computed waveform expectations.
module tb_uart_tx_buffered;
  localparam int CLK_HZ = 1152000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11 * DIV;
`else
  localparam int FL = 10 * DIV;
`endif
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr    = 1'b0;
  logic          clr   = 1'b0;
  logic [7:0]    din   = 8'h00;
  logic          full, empty, ovf, tx, busy;
  logic [CW-1:0] count;

  uart_tx_buffered #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_Clock(clk),
    .i_Reset_n(rst_n),
    .i_Write(wr),
    .i_Data(din),
    .o_Full(full),
    .o_Empty(empty),
    .o_Count(count),
    .o_Overflow(ovf),
    .i_Clear_Overflow(clr),
    .o_TX(tx),
    .o_Busy_TX(busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: FIFO as a queue, the line as "which bit slot of which frame".
  logic [7:0] mq[$];
  logic [7:0] m_cur   = 8'h00;
  int         m_phase = -1;
  logic       m_ovf   = 1'b0;

  always @(posedge clk) begin : model
    bit full_b, empty_b;
    cyc++;
    if (!rst_n) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_phase = -1;
    end else begin
      full_b  = (mq.size() == DEPTH);
      empty_b = (mq.size() == 0);
      if (m_phase < 0) begin
        if (!empty_b) begin
          m_cur   = mq.pop_front();
          m_phase = 0;
        end
      end else begin
        m_phase++;
        if (m_phase == FL) begin
          if (!empty_b) begin
            m_cur   = mq.pop_front();
            m_phase = 0;
          end else begin
            m_phase = -1;
          end
        end
      end
      if (wr && !full_b) mq.push_back(din);
      if (wr && full_b) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
  end

  function automatic logic exp_tx();
    int slot;
    if (m_phase < 0) return 1'b1;
    slot = m_phase / DIV;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_cur[3'(slot - 1)];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_tx",    32'(tx),    32'(exp_tx()));
      chk("m_busy",  32'(busy),  32'(m_phase >= 0));
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_full",  32'(full),  32'(mq.size() == DEPTH));
      chk("m_ovf",   32'(ovf),   32'(m_ovf));
    end
  end

  logic txlog [0:511];

  // Writes n bytes on consecutive cycles and checks the resulting line capture.
  task automatic burst(input logic [23:0] bytes, input int n);
    int s0, nb, base;
    logic [7:0] got;
    nb = 0;
    s0 = -1;
    for (int t = 0; t < n * FL + 40; t++) begin
      @(negedge clk);
      txlog[t] = tx;
      if (busy) nb++;
      if (t < n) begin
        wr  = 1'b1;
        din = bytes[8*t +: 8];
      end else begin
        wr = 1'b0;
      end
    end
    for (int t = 0; t < n * FL + 40; t++) begin
      if (s0 < 0 && txlog[t] == 1'b0) s0 = t;
    end
    chk("burst_busy_len", 32'(nb), 32'(n * FL));
    chk("burst_first_start", 32'(s0), 32'(2));
    if (s0 == 2) begin
      for (int i = 0; i < n; i++) begin
        base = s0 + i * FL;
        if (i > 0) chk("burst_prev_stop", 32'(txlog[base - 1]), 32'(1));
        chk("burst_start_bit", 32'(txlog[base]), 32'(0));
        for (int j = 0; j < 8; j++) got[3'(j)] = txlog[base + DIV * (j + 1) + DIV / 2];
        chk("burst_byte", 32'(got), 32'(bytes[8*i +: 8]));
`ifdef UART_TX_PARITY_EN
        chk("burst_parity", 32'(txlog[base + 9 * DIV + DIV / 2]), 32'(^bytes[8*i +: 8]));
`endif
        chk("burst_stop_bit", 32'(txlog[base + FL - DIV / 2]), 32'(1));
      end
    end
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n0;
    logic [10:0] pat55;
`ifdef UART_TX_PARITY_EN
    pat55 = 11'b10010101010;
`else
    pat55 = 11'b01010101010;
`endif
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_tx",    32'(tx),    32'(1));
    chk("rst_busy",  32'(busy),  32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_full",  32'(full),  32'(0));
    chk("rst_ovf",   32'(ovf),   32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0x55: start, 1,0,1,0,1,0,1,0, (parity), stop.
    wr = 1'b1; din = 8'h55; n0 = cyc + 1;
    @(negedge clk);
    wr = 1'b0;
    chk("t1_empty_after_write", 32'(empty), 32'(0));
    for (int k = 1; k <= FL + 5; k++) begin
      @(negedge clk);
      if (k <= FL) chk("t1_tx", 32'(tx), 32'(pat55[4'((k - 1) / DIV)]));
      if (k == FL)     chk("t1_busy_last", 32'(busy), 32'(1));
      if (k == FL + 1) chk("t1_busy_fall", 32'(busy), 32'(0));
    end
    repeat (5) @(negedge clk);

    // Back-to-back frames.
    burst(24'hFF3CA5, 3);
    repeat (10) @(negedge clk);

    // Overflow: one byte goes to the serialiser, 16 fill the FIFO, the 18th drops.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      wr = 1'b1; din = 8'($urandom);
    end
    @(negedge clk);
    wr = 1'b0;
    chk("t3_full",  32'(full),  32'(1));
    chk("t3_count", 32'(count), 32'(16));
    chk("t3_ovf",   32'(ovf),   32'(1));
    // Keep hammering while full so some writes land on STOP pop cycles.
    for (int i = 0; i < 2 * FL + 50; i++) begin
      wr = 1'b1; din = 8'($urandom);
      @(negedge clk);
    end
    wr = 1'b0;
    chk("t4_ovf_sticky", 32'(ovf), 32'(1));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t3_ovf_cleared", 32'(ovf), 32'(0));
    repeat (17 * FL + 20) @(negedge clk);

    // Push on the exact STOP pop cycle leaves the count unchanged.
    wr = 1'b1; din = 8'h81; n0 = cyc + 1;
    @(negedge clk);
    din = 8'h42;
    @(negedge clk);
    wr = 1'b0;
    while (cyc < n0 + FL) @(negedge clk);
    chk("t4_count_before", 32'(count), 32'(1));
    wr = 1'b1; din = 8'h5A;
    @(negedge clk);
    wr = 1'b0;
    chk("t4_count_after", 32'(count), 32'(1));
    chk("t4_next_start", 32'(tx), 32'(0));
    chk("t4_busy", 32'(busy), 32'(1));
    repeat (3 * FL + 20) @(negedge clk);

    // Reset during data bit 3 of 0x0F with a second byte queued.
    wr = 1'b1; din = 8'h0F; n0 = cyc + 1;
    @(negedge clk);
    din = 8'h33;
    @(negedge clk);
    wr = 1'b0;
    while (cyc < n0 + 4 * DIV + 4) @(negedge clk);
    chk("t5_bit3", 32'(tx), 32'(1));
    chk("t5_count_pre", 32'(count), 32'(1));
    rst_n = 1'b0;
    wr = 1'b1; din = 8'hEE;
    @(negedge clk);
    rst_n = 1'b1;
    wr = 1'b0;
    chk("t5_tx", 32'(tx), 32'(1));
    chk("t5_count", 32'(count), 32'(0));
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_empty", 32'(empty), 32'(1));
    for (int i = 0; i < 2 * FL; i++) begin
      @(negedge clk);
      chk("t5_quiet", 32'(tx), 32'(1));
    end

`ifdef UART_TX_PARITY_EN
    burst(24'h000307, 2);
    chk("t6_par_07", 32'(txlog[2 + 9 * DIV + DIV / 2]), 32'(1));
    chk("t6_par_03", 32'(txlog[2 + 110 + 9 * DIV + DIV / 2]), 32'(0));
    chk("t6_frame2_start", 32'(txlog[2 + 110]), 32'(0));
    chk("t6_frame1_stop_end", 32'(txlog[2 + 109]), 32'(1));
    repeat (10) @(negedge clk);
`endif

    // Randomized traffic with varying write pressure, clears and rare resets.
    for (int seg = 0; seg < 6; seg++) begin
      int pw;
      pw = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 30 : 4);
      for (int c = 0; c < 600; c++) begin
        wr    = ($urandom_range(99) < pw);
        din   = 8'($urandom);
        clr   = ($urandom_range(39) == 0);
        rst_n = ($urandom_range(799) != 0);
        @(negedge clk);
      end
    end
    wr = 1'b0; clr = 1'b0; rst_n = 1'b1;
    repeat (17 * FL + 20) @(negedge clk);
    chk("end_idle_tx", 32'(tx), 32'(1));
    chk("end_idle_empty", 32'(empty), 32'(1));

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
